// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between buart, the RX FIFO and the CPU I/O read path.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
);
    logic                  uart_valid;
    logic [WIDTH-1:0]      uart_data;
    logic                  uart_rd;
    logic                  cpu_rd;
    logic [WIDTH-1:0]      cpu_data;
    logic                  cpu_valid;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  stall;
    logic                  clr_stall;

    modport master (
        output uart_valid, uart_data, cpu_rd, clr_stall,
        input  uart_rd, cpu_data, cpu_valid, full, count, stall
    );

    modport slave (
        input  uart_valid, uart_data, cpu_rd, clr_stall,
        output uart_rd, cpu_data, cpu_valid, full, count, stall
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer: drains buart one byte per acknowledge into a
// first-word-fall-through FIFO read by the CPU.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic            clk,
    input  logic            resetq,
    uart_rx_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2:0]   cnt;
    logic [0:0]            state;
    logic                  stall_q;
    logic                  full_q;
    logic                  nonempty;
    logic                  push;
    logic                  pop;

    assign full_q   = (cnt == DEPTH_CNT);
    assign nonempty = (cnt != '0);
    assign push     = !resetq && (state == IDLE) && bus.uart_valid && !full_q;
    assign pop      = !resetq && bus.cpu_rd && nonempty;

    // Outputs are held quiet while reset is asserted, not just after it.
    assign bus.uart_rd   = push;
    assign bus.cpu_valid = !resetq && nonempty;
    assign bus.full      = !resetq && full_q;
    assign bus.stall     = !resetq && stall_q;
    assign bus.count     = cnt;
    assign bus.cpu_data  = bus.cpu_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= bus.uart_data;
    end

    always_ff @(posedge clk) begin
        if (resetq) begin
            state   <= IDLE;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            stall_q <= 1'b0;
        end else begin
            state <= push ? ACK : IDLE;
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A new blocked byte outranks a clear in the same cycle.
            if ((state == IDLE) && bus.uart_valid && full_q)
                stall_q <= 1'b1;
            else if (bus.clr_stall)
                stall_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic resetq;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a byte on buart until it is acknowledged, then drop it.
    task automatic push_byte(input logic [7:0] b);
        int n;
        bus.uart_valid = 1'b1;
        bus.uart_data  = b;
        #1;
        n = 0;
        while (!bus.uart_rd && n < 20) begin
            tick();
            n++;
        end
        vec++;
        if (!bus.uart_rd) begin
            err++;
            $display("FAIL push_ack data=%h: uart_rd=%b required 1", b, bus.uart_rd);
        end
        tick();
        bus.uart_valid = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b);
        bus.cpu_rd = 1'b1;
        #1;
        b = bus.cpu_data;
        tick();
        bus.cpu_rd = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        resetq = 1'b1;
        bus.uart_valid = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.clr_stall = 1'b0;
        tick();
        tick();
        resetq = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetq = 1'b1;
        bus.uart_valid = 1'b1;
        bus.uart_data = 8'h5A;
        bus.cpu_rd = 1'b0;
        bus.clr_stall = 1'b0;
        tick();
        vec++;
        if (bus.uart_rd !== 1'b0) begin
            err++;
            $display("FAIL reset_uart_rd: got %b required 0", bus.uart_rd);
        end
        tick();
        bus.uart_valid = 1'b0;
        resetq = 1'b0;
        #1;
        vec++;
        if ({bus.uart_rd, bus.cpu_valid, bus.full, bus.stall} !== 4'b0000) begin
            err++;
            $display("FAIL reset_flags: got %b required 0000",
                     {bus.uart_rd, bus.cpu_valid, bus.full, bus.stall});
        end
        vec++;
        if (bus.cpu_data !== 8'h00 || bus.count !== 5'd0) begin
            err++;
            $display("FAIL reset_data_count: got %h/%0d required 00/0",
                     bus.cpu_data, bus.count);
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        bus.uart_valid = 1'b1;
        bus.uart_data = 8'h41;
        #1;
        if (bus.uart_rd) pulses++;
        tick();
        if (bus.uart_rd) pulses++;
        vec++;
        if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== 8'h41 || bus.count !== 5'd1) begin
            err++;
            $display("FAIL single_head: got v=%b d=%h c=%0d required 1/41/1",
                     bus.cpu_valid, bus.cpu_data, bus.count);
        end
        tick();
        bus.uart_valid = 1'b0;
        vec++;
        if (pulses != 1 || bus.count !== 5'd1) begin
            err++;
            $display("FAIL single_pulse: got %0d pulses count=%0d required 1/1",
                     pulses, bus.count);
        end
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        #1;
        vec++;
        if (bus.count !== 5'd0 || bus.cpu_valid !== 1'b0 || bus.cpu_data !== 8'h00) begin
            err++;
            $display("FAIL single_pop: got c=%0d v=%b d=%h required 0/0/00",
                     bus.count, bus.cpu_valid, bus.cpu_data);
        end
    endtask

    task automatic test_fill();
        logic [7:0] b;
        int n;
        for (int i = 0; i < 16; i++)
            push_byte(8'(i));
        vec++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            err++;
            $display("FAIL fill_full: got full=%b count=%0d required 1/16",
                     bus.full, bus.count);
        end
        bus.uart_valid = 1'b1;
        bus.uart_data = 8'h10;
        tick();
        tick();
        vec++;
        if (bus.stall !== 1'b1 || bus.uart_rd !== 1'b0) begin
            err++;
            $display("FAIL fill_stall: got stall=%b uart_rd=%b required 1/0",
                     bus.stall, bus.uart_rd);
        end
        pop_byte(b);
        vec++;
        if (b !== 8'h00) begin
            err++;
            $display("FAIL fill_pop_head: got %h required 00", b);
        end
        n = 0;
        while (!bus.uart_rd && n < 2) begin
            tick();
            n++;
        end
        tick();
        bus.uart_valid = 1'b0;
        vec++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            err++;
            $display("FAIL fill_recover: got full=%b count=%0d required 1/16",
                     bus.full, bus.count);
        end
        bus.clr_stall = 1'b1;
        tick();
        bus.clr_stall = 1'b0;
        vec++;
        if (bus.stall !== 1'b0) begin
            err++;
            $display("FAIL fill_clr_stall: got %b required 0", bus.stall);
        end
        for (int i = 1; i <= 16; i++) begin
            pop_byte(b);
            vec++;
            if (b !== 8'(i)) begin
                err++;
                $display("FAIL fill_drain[%0d]: got %h required %h", i, b, 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int i = 0; i < 10; i++)
            push_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            pop_byte(b);
            vec++;
            if (b !== 8'hA0 + 8'(i)) begin
                err++;
                $display("FAIL wrap_first[%0d]: got %h required %h", i, b, 8'hA0 + 8'(i));
            end
        end
        for (int i = 0; i < 12; i++) begin
            push_byte(8'h20 + 8'(i));
            vec++;
            if (bus.count !== 5'(i + 1)) begin
                err++;
                $display("FAIL wrap_cnt_up[%0d]: got %0d required %0d", i, bus.count, i + 1);
            end
        end
        for (int i = 0; i < 12; i++) begin
            pop_byte(b);
            vec++;
            if (b !== 8'h20 + 8'(i) || bus.count !== 5'(11 - i)) begin
                err++;
                $display("FAIL wrap_pop[%0d]: got %h/%0d required %h/%0d",
                         i, b, bus.count, 8'h20 + 8'(i), 11 - i);
            end
        end
    endtask

    task automatic test_simul();
        logic [7:0] b;
        logic [7:0] exp [3];
        exp[0] = 8'h62;
        exp[1] = 8'h63;
        exp[2] = 8'h55;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        tick();
        bus.uart_valid = 1'b1;
        bus.uart_data = 8'h55;
        bus.cpu_rd = 1'b1;
        #1;
        vec++;
        if (bus.uart_rd !== 1'b1 || bus.cpu_data !== 8'h61) begin
            err++;
            $display("FAIL simul_both: got rd=%b head=%h required 1/61",
                     bus.uart_rd, bus.cpu_data);
        end
        tick();
        bus.uart_valid = 1'b0;
        bus.cpu_rd = 1'b0;
        #1;
        vec++;
        if (bus.count !== 5'd3) begin
            err++;
            $display("FAIL simul_count: got %0d required 3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            pop_byte(b);
            vec++;
            if (b !== exp[i]) begin
                err++;
                $display("FAIL simul_order[%0d]: got %h required %h", i, b, exp[i]);
            end
        end
    endtask

    task automatic test_empty();
        logic [7:0] b;
        bus.cpu_rd = 1'b1;
        tick();
        tick();
        bus.cpu_rd = 1'b0;
        #1;
        vec++;
        if (bus.count !== 5'd0 || bus.cpu_valid !== 1'b0) begin
            err++;
            $display("FAIL empty_rd: got count=%0d valid=%b required 0/0",
                     bus.count, bus.cpu_valid);
        end
        push_byte(8'h77);
        pop_byte(b);
        vec++;
        if (b !== 8'h77 || bus.count !== 5'd0) begin
            err++;
            $display("FAIL empty_after: got %h/%0d required 77/0", b, bus.count);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        for (int i = 0; i < 5; i++)
            push_byte(8'h30 + 8'(i));
        vec++;
        if (bus.count !== 5'd5) begin
            err++;
            $display("FAIL mid_pre: got count=%0d required 5", bus.count);
        end
        resetq = 1'b1;
        tick();
        resetq = 1'b0;
        #1;
        vec++;
        if (bus.count !== 5'd0 || bus.uart_rd !== 1'b0 || bus.stall !== 1'b0) begin
            err++;
            $display("FAIL mid_reset: got c=%0d rd=%b stall=%b required 0/0/0",
                     bus.count, bus.uart_rd, bus.stall);
        end
        push_byte(8'h99);
        pop_byte(b);
        vec++;
        if (b !== 8'h99) begin
            err++;
            $display("FAIL mid_next: got %h required 99", b);
        end
    endtask

    task automatic test_stall_prio();
        for (int i = 0; i < 16; i++)
            push_byte(8'hC0 + 8'(i));
        bus.uart_valid = 1'b1;
        bus.uart_data = 8'hEE;
        bus.clr_stall = 1'b1;
        tick();
        tick();
        vec++;
        if (bus.stall !== 1'b1) begin
            err++;
            $display("FAIL stall_set_wins: got %b required 1", bus.stall);
        end
        bus.uart_valid = 1'b0;
        tick();
        bus.clr_stall = 1'b0;
        vec++;
        if (bus.stall !== 1'b0) begin
            err++;
            $display("FAIL stall_clear: got %b required 0", bus.stall);
        end
        do_reset();
    endtask

    initial begin
        bus.uart_valid = 1'b0;
        bus.uart_data = 8'h00;
        bus.cpu_rd = 1'b0;
        bus.clr_stall = 1'b0;
        resetq = 1'b1;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simul();
        test_empty();
        test_reset_mid();
        test_stall_prio();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the buart receiver and the CPU I/O read path.
- Drains each received byte from buart as soon as it is valid and acknowledges it with a one-cycle read strobe, so buart's single-byte holding register is freed quickly.
- Holds bytes in a first-word-fall-through FIFO that the CPU pops through the UART RX I/O read (io_rd_ & io_addr_[12]).
- Exports not-empty, full, fill count and a sticky stall flag for the misc.in status word.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in bytes (default depth 16).
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetq  input  1  synchronous reset, active-high (1 = reset), sampled on posedge clk.
- uart_valid  input  1  buart has a received byte pending.
- uart_data  input  WIDTH  buart received byte; valid while uart_valid = 1.
- uart_rd  output  1  one-cycle acknowledge to buart; consumes the pending byte.
- cpu_rd  input  1  pop strobe from the CPU I/O read decode.
- cpu_data  output  WIDTH  head of FIFO (fall-through); 0 when empty.
- cpu_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
- count  output  DEPTH_LOG2+1  number of bytes stored, 0..2^DEPTH_LOG2.
- stall  output  1  sticky: a byte was pending while the FIFO was full.
- clr_stall  input  1  clears stall.

Behaviour:
- Reset:
  - Applies when resetq = 1 at posedge, including mid-transfer.
  - Pointers and count go to 0. FSM goes to IDLE.
  - Outputs during and after reset: uart_rd = 0, cpu_valid = 0, full = 0, stall = 0, cpu_data = 0.
  - Storage array contents are not reset.
- Storage:
  - Array of 2^DEPTH_LOG2 x WIDTH.
  - Write pointer wp and read pointer rp are DEPTH_LOG2 bits and wrap modulo depth.
  - count is held in a separate register.
- Ingress FSM:
  - IDLE:
    - If uart_valid && !full: write uart_data to mem[wp], wp++, assert uart_rd for this cycle only, go to ACK.
    - Else stay in IDLE with uart_rd = 0.
  - ACK:
    - One dead cycle; uart_rd = 0. Gives buart one cycle to drop uart_valid. Always returns to IDLE.
    - No push is allowed in ACK. This guarantees one byte per acknowledge.
  - Ingress throughput: at most one byte every 2 cycles.
- Egress:
  - cpu_data = mem[rp] when cpu_valid, else 0. This is combinational from the registered rp.
  - A pop occurs when cpu_rd && cpu_valid; rp++ at that edge.
  - cpu_rd while empty is ignored: no pointer or count change.
- Count:
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged, both pointers advance.
  - cpu_valid = (count != 0). full = (count == 2^DEPTH_LOG2).
  - Push is never attempted when full, so count never exceeds depth.
  - Pop is never performed when empty, so count never underflows.
- Latency:
  - A byte accepted at edge E appears on cpu_data with cpu_valid = 1 in the cycle after E.
  - If the FIFO was not empty, the byte sits behind earlier bytes in order.
- Full:
  - While full, uart_valid is left unacknowledged (uart_rd = 0) and the byte stays in buart.
  - stall is set at every edge where state = IDLE && uart_valid && full.
- stall:
  - Cleared by clr_stall = 1.
  - If set and clear conditions occur in the same cycle, set wins.
- Full recovery:
  - When a pop occurs while full and the FSM is in IDLE with uart_valid pending, the push is deferred to the next cycle. full is evaluated on registered count.
- Ordering: strict FIFO order across pointer wrap-around.

Test Plan:
- Single byte: after reset, uart_valid = 1 with uart_data = 0x41 for 2 cycles -> uart_rd pulses for exactly 1 cycle; next cycle cpu_valid = 1, cpu_data = 0x41, count = 1. Then cpu_rd for 1 cycle -> count = 0, cpu_valid = 0, cpu_data = 0.
- Fill: push 0x00..0x0F back-to-back, each held until uart_rd -> full = 1, count = 16. Present 0x10 -> no uart_rd, stall = 1. Pop one -> cpu_data was 0x00; within 2 cycles 0x10 is accepted and full = 1 again.
- Wrap-around: push 10 bytes, pop 10, push 0x20..0x2B, pop all -> read order is 0x20..0x2B, and count tracks 12 down to 0.
- Simultaneous: with count = 3, a push of 0x55 coincides with a pop of the head -> count stays 3, 0x55 is last out.
- Empty read: cpu_rd pulsed with count = 0 -> count stays 0, no pointer change; a subsequent push and pop returns the correct byte.
- Reset mid-operation: with count = 5 and the FSM in ACK, assert resetq for 1 cycle -> count = 0, uart_rd = 0, stall = 0. The next uart_valid is accepted normally. Separately, clr_stall and a stall-set condition in the same cycle -> stall = 1.
